// File: rtl/bru_pred.sv
// Branch resolution and BHT-based direction prediction for an N-wide execute stage.
// Resolves lanes oldest-first, trains 2-bit counters, and emits one registered redirect per cycle.

module bru_lane (
  input  logic [3:0]  opc_i,
  input  logic        eq_i,
  input  logic        lt_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] jmp_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_addr_i,
  output logic        taken_o,
  output logic        mis_o,
  output logic        trainable_o,
  output logic [31:0] npc_o
);
  always_comb begin
    taken_o = 1'b0;
    if (opc_i[3]) taken_o = 1'b1;
    else begin
      case (opc_i[2:0])
        3'b000:          taken_o = eq_i;
        3'b001:          taken_o = !eq_i;
        3'b100, 3'b110:  taken_o = lt_i;
        3'b101, 3'b111:  taken_o = !lt_i;
        default:         taken_o = 1'b0;
      endcase
    end
  end

  // funct3 010/011 are not real branches: resolved not-taken, never trained
  assign trainable_o = !opc_i[3] && (opc_i[2:1] != 2'b01);
  assign mis_o       = (taken_o != pred_taken_i) || (taken_o && (pred_addr_i != jmp_i));
  assign npc_o       = taken_o ? jmp_i : pc_i + 32'd4;
endmodule

module bru_pred #(
  parameter int         LANES     = 2,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] RESET_CTR = 2'b01,
  localparam int        IDXW      = $clog2(BHT_DEPTH),
  localparam int        SRCW      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req_i,
  input  logic [31:0]           pred_pc_i,
  output logic                  pred_valid_o,
  output logic                  pred_taken_o,
  input  logic [LANES-1:0]      res_valid_i,
  input  logic [LANES*4-1:0]    res_opc_i,
  input  logic [LANES-1:0]      res_eq_i,
  input  logic [LANES-1:0]      res_lt_i,
  input  logic [LANES*32-1:0]   res_pc_i,
  input  logic [LANES*32-1:0]   res_jmp_addr_i,
  input  logic [LANES-1:0]      res_pred_taken_i,
  input  logic [LANES*32-1:0]   res_pred_addr_i,
  output logic                  redirect_valid_o,
  output logic [SRCW-1:0]       redirect_src_o,
  output logic [31:0]           redirect_addr_o,
  output logic [31:0]           mispred_cnt_o
);
  logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
  logic                      pred_valid_q, pred_taken_q;
  logic                      redirect_valid_q, redirect_valid_d;
  logic [SRCW-1:0]           redirect_src_q, redirect_src_d;
  logic [31:0]               redirect_addr_q, redirect_addr_d;
  logic [31:0]               mispred_cnt_q;

  logic [LANES-1:0][31:0]    lane_pc, lane_npc;
  logic [LANES-1:0]          lane_taken, lane_mis, lane_train;

  logic unused_pc;
  assign unused_pc = ^{pred_pc_i[31:IDXW+2], pred_pc_i[1:0]};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_pc[l] = res_pc_i[l*32 +: 32];
    bru_lane u_lane (
      .opc_i        (res_opc_i[l*4 +: 4]),
      .eq_i         (res_eq_i[l]),
      .lt_i         (res_lt_i[l]),
      .pc_i         (lane_pc[l]),
      .jmp_i        (res_jmp_addr_i[l*32 +: 32]),
      .pred_taken_i (res_pred_taken_i[l]),
      .pred_addr_i  (res_pred_addr_i[l*32 +: 32]),
      .taken_o      (lane_taken[l]),
      .mis_o        (lane_mis[l]),
      .trainable_o  (lane_train[l]),
      .npc_o        (lane_npc[l])
    );
  end

  logic [IDXW-1:0] tidx;
  logic [1:0]      ctr;

  // Walk lanes oldest-first; training applies to bht_d so same-index lanes accumulate.
  always_comb begin
    bht_d            = bht_q;
    redirect_valid_d = 1'b0;
    redirect_src_d   = redirect_src_q;
    redirect_addr_d  = redirect_addr_q;
    tidx             = '0;
    ctr              = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!redirect_valid_d && !redirect_valid_q && res_valid_i[l]) begin
        if (lane_train[l]) begin
          tidx = lane_pc[l][IDXW+1:2];
          ctr  = bht_d[tidx];
          if (lane_taken[l]) begin
            if (ctr != 2'b11) ctr = ctr + 2'b01;
          end else begin
            if (ctr != 2'b00) ctr = ctr - 2'b01;
          end
          bht_d[tidx] = ctr;
        end
        if (lane_mis[l]) begin
          redirect_valid_d = 1'b1;
          redirect_src_d   = SRCW'(l);
          redirect_addr_d  = lane_npc[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bht_q            <= {BHT_DEPTH{RESET_CTR}};
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_src_q   <= '0;
      redirect_addr_q  <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      bht_q            <= bht_d;
      pred_valid_q     <= pred_req_i;
      pred_taken_q     <= bht_q[pred_pc_i[IDXW+1:2]][1];
      redirect_valid_q <= redirect_valid_d;
      redirect_src_q   <= redirect_src_d;
      redirect_addr_q  <= redirect_addr_d;
      if (redirect_valid_d) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign pred_valid_o     = pred_valid_q;
  assign pred_taken_o     = pred_taken_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_src_o   = redirect_src_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign mispred_cnt_o    = mispred_cnt_q;
endmodule

// File: tb/tb_bru_pred.sv
// Self-checking bench for bru_pred: constant vector table, directed corner sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_bru_pred;
  localparam int LANES = 2;
  localparam int DEPTH = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pred_req;
  logic [31:0]        pred_pc;
  logic               pred_valid, pred_taken;
  logic [LANES-1:0]   res_valid, res_eq, res_lt, res_pt;
  logic [LANES*4-1:0] res_opc;
  logic [LANES*32-1:0] res_pc, res_ja, res_pa;
  logic               redirect_valid;
  logic [0:0]         redirect_src;
  logic [31:0]        redirect_addr, mispred_cnt;

  always #5 clk = ~clk;

  bru_pred #(.LANES(LANES), .BHT_DEPTH(DEPTH), .RESET_CTR(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .pred_req_i(pred_req), .pred_pc_i(pred_pc),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
    .res_valid_i(res_valid), .res_opc_i(res_opc), .res_eq_i(res_eq), .res_lt_i(res_lt),
    .res_pc_i(res_pc), .res_jmp_addr_i(res_ja), .res_pred_taken_i(res_pt),
    .res_pred_addr_i(res_pa), .redirect_valid_o(redirect_valid),
    .redirect_src_o(redirect_src), .redirect_addr_o(redirect_addr),
    .mispred_cnt_o(mispred_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_bht[DEPTH];
  bit          m_rv, m_pv, m_pt;
  int          m_src;
  logic [31:0] m_addr, m_cnt;

  function automatic bit f_taken(input logic [3:0] o, input logic e, input logic lt);
    if (o[3]) return 1'b1;
    case (o[2:0])
      3'd0: return e;
      3'd1: return !e;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit npt;
    npt = (m_bht[pred_pc[7:2]] >= 2);
    if (!rst_n) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_rv = 0; m_src = 0; m_addr = 0; m_cnt = 0; m_pv = 0; m_pt = 0;
      return;
    end
    m_pv = pred_req;
    m_pt = npt;
    if (m_rv) begin
      m_rv = 0;   // squashed shadow cycle
      return;
    end
    for (int l = 0; l < LANES; l++) begin
      if (res_valid[l]) begin
        logic [3:0]  o;
        logic [31:0] pc, ja, pa;
        bit t;
        int i;
        o  = res_opc[l*4 +: 4];
        pc = res_pc[l*32 +: 32];
        ja = res_ja[l*32 +: 32];
        pa = res_pa[l*32 +: 32];
        t  = f_taken(o, res_eq[l], res_lt[l]);
        if (!o[3] && o[2:1] != 2'b01) begin
          i = int'(pc[7:2]);
          if (t) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
          else   m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
        end
        if (t != res_pt[l] || (t && pa != ja)) begin
          m_rv = 1; m_src = l; m_addr = t ? ja : pc + 32'd4; m_cnt = m_cnt + 32'd1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    chk("redirect_src", {31'd0, redirect_src}, 32'(m_src));
    chk("redirect_addr", redirect_addr, m_addr);
    chk("mispred_cnt", mispred_cnt, m_cnt);
  endtask

  task automatic idle();
    res_valid = '0; pred_req = 1'b0;
  endtask

  task automatic set_lane(input int l, input bit v, input logic [3:0] o, input bit e,
                          input bit lt, input logic [31:0] pc, input logic [31:0] ja,
                          input bit pt, input logic [31:0] pa);
    res_valid[l] = v; res_opc[l*4 +: 4] = o; res_eq[l] = e; res_lt[l] = lt;
    res_pc[l*32 +: 32] = pc; res_ja[l*32 +: 32] = ja; res_pt[l] = pt;
    res_pa[l*32 +: 32] = pa;
  endtask

  task automatic pred_chk(input logic [31:0] pc, input bit exp, input string nm);
    idle(); pred_req = 1'b1; pred_pc = pc;
    tick();
    chk(nm, {31'd0, pred_taken}, {31'd0, exp});
    pred_req = 1'b0;
  endtask

  // BEQ resolved with a correct prediction: trains without redirecting
  task automatic beq_ok(input int l, input logic [31:0] pc, input bit t);
    set_lane(l, 1'b1, 4'b0000, t, 1'b0, pc, 32'h300, t, 32'h300);
  endtask

  typedef struct {
    bit v0, v1; logic [3:0] o0, o1; bit e0, e1, l0, l1, p0, p1;
    logic [31:0] pc0, pc1, j0, j1, a0, a1;
    bit erv; int esrc; logic [31:0] eaddr;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] saved_cnt;

  initial begin
    tbl[0] = '{1,0, 4'b0001,4'b0000, 1,0,0,0, 1,0, 32'h40,0, 32'h99,0, 0,0, 1,0,32'h44};
    tbl[1] = '{1,0, 4'b1000,4'b0000, 0,0,0,0, 1,0, 32'h1000,0, 32'h90,0, 32'h80,0, 1,0,32'h90};
    tbl[2] = '{1,1, 4'b0100,4'b0101, 0,0,1,1, 0,1, 32'h308,32'h30C, 32'h340,32'h50, 0,32'h60, 1,0,32'h340};
    tbl[3] = '{1,1, 4'b0000,4'b1000, 0,0,0,0, 0,0, 32'h500,32'h504, 32'h10,32'h600, 0,0, 1,1,32'h600};
    tbl[4] = '{1,0, 4'b0111,4'b0000, 0,0,0,0, 1,0, 32'h6F0,0, 32'h700,0, 32'h700,0, 0,1,32'h600};
    tbl[5] = '{1,0, 4'b0010,4'b0000, 1,0,1,0, 0,0, 32'h800,0, 32'h900,0, 0,0, 0,1,32'h600};
    tbl[6] = '{1,0, 4'b0011,4'b0000, 0,0,0,0, 1,0, 32'hFFFF_FFFC,0, 32'h900,0, 32'h900,0, 1,0,32'h0};
    tbl[7] = '{1,0, 4'b0110,4'b0000, 0,0,0,0, 1,0, 32'h10,0, 32'h70,0, 32'h70,0, 1,0,32'h14};
    tbl[8] = '{0,1, 4'b0000,4'b0001, 0,0,0,0, 0,0, 0,32'h20, 0,32'h1234, 0,0, 1,1,32'h1234};
    tbl[9] = '{1,1, 4'b1000,4'b0000, 0,0,0,0, 1,0, 32'h44,32'h48, 32'h44,32'h88, 32'h44,0, 0,1,32'h1234};

    rst_n = 1'b0; pred_pc = '0; res_opc = '0; res_eq = '0; res_lt = '0; res_pt = '0;
    res_pc = '0; res_ja = '0; res_pa = '0;
    idle();
    tick(); tick();
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    chk("rst_redirect_addr", redirect_addr, 32'd0);
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    rst_n = 1'b1;

    // first prediction: weakly not-taken
    pred_req = 1'b1; pred_pc = 32'h100;
    tick();
    chk("pred1_valid", {31'd0, pred_valid}, 32'd1);
    chk("pred1_taken", {31'd0, pred_taken}, 32'd0);
    pred_req = 1'b0;
    tick();
    chk("pred1_drop", {31'd0, pred_valid}, 32'd0);

    // BEQ taken but predicted not-taken
    set_lane(0, 1'b1, 4'b0000, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0, 32'h0);
    tick();
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq_src", {31'd0, redirect_src}, 32'd0);
    chk("beq_addr", redirect_addr, 32'h200);
    chk("beq_cnt", mispred_cnt, 32'd1);
    pred_chk(32'h100, 1'b1, "beq_trained");
    idle(); tick();

    foreach (tbl[k]) begin
      set_lane(0, tbl[k].v0, tbl[k].o0, tbl[k].e0, tbl[k].l0, tbl[k].pc0, tbl[k].j0, tbl[k].p0, tbl[k].a0);
      set_lane(1, tbl[k].v1, tbl[k].o1, tbl[k].e1, tbl[k].l1, tbl[k].pc1, tbl[k].j1, tbl[k].p1, tbl[k].a1);
      tick();
      chk($sformatf("tbl%0d_rv", k), {31'd0, redirect_valid}, {31'd0, tbl[k].erv});
      chk($sformatf("tbl%0d_src", k), {31'd0, redirect_src}, 32'(tbl[k].esrc));
      chk($sformatf("tbl%0d_addr", k), redirect_addr, tbl[k].eaddr);
      idle(); tick();
    end

    // saturation at 3 and at 0 on idx 40
    idle();
    for (int n = 0; n < 4; n++) begin beq_ok(0, 32'hA0, 1'b1); tick(); end
    pred_chk(32'hA0, 1'b1, "sat_hi");
    beq_ok(0, 32'hA0, 1'b0); tick();
    pred_chk(32'hA0, 1'b1, "sat_hi_dec1");
    beq_ok(0, 32'hA0, 1'b0); tick();
    pred_chk(32'hA0, 1'b0, "sat_hi_dec2");
    for (int n = 0; n < 5; n++) begin beq_ok(0, 32'hA0, 1'b0); tick(); end
    beq_ok(0, 32'hA0, 1'b1); tick();
    pred_chk(32'hA0, 1'b0, "sat_lo_inc1");
    beq_ok(0, 32'hA0, 1'b1); tick();
    pred_chk(32'hA0, 1'b1, "sat_lo_inc2");

    // two lanes on one index accumulate: 01 -> 11
    beq_ok(0, 32'hC4, 1'b1); beq_ok(1, 32'hC4, 1'b1); tick();
    idle(); beq_ok(0, 32'hC4, 1'b0); tick();
    pred_chk(32'hC4, 1'b1, "dual_lane_cumulative");

    // shadow cycle squashes resolves
    set_lane(0, 1'b1, 4'b0000, 1'b1, 1'b0, 32'hE0, 32'h400, 1'b0, 32'h0);
    tick();
    saved_cnt = mispred_cnt;
    chk("shadow_first_addr", redirect_addr, 32'h400);
    set_lane(0, 1'b1, 4'b0000, 1'b0, 1'b0, 32'hE0, 32'h0, 1'b1, 32'h500);
    tick();
    chk("shadow_rv", {31'd0, redirect_valid}, 32'd0);
    chk("shadow_addr_hold", redirect_addr, 32'h400);
    chk("shadow_cnt", mispred_cnt, saved_cnt);
    pred_chk(32'hE0, 1'b1, "shadow_no_train");

    // reset mid-stream beats a pending mispredict and prediction
    set_lane(0, 1'b1, 4'b1000, 1'b0, 1'b0, 32'h10, 32'h999, 1'b0, 32'h0);
    pred_req = 1'b1; pred_pc = 32'hA0; rst_n = 1'b0;
    tick();
    chk("mrst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("mrst_pv", {31'd0, pred_valid}, 32'd0);
    chk("mrst_cnt", mispred_cnt, 32'd0);
    chk("mrst_addr", redirect_addr, 32'd0);
    rst_n = 1'b1;
    pred_chk(32'hA0, 1'b0, "mrst_bht_reset");

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      pred_req = $urandom_range(0, 1);
      pred_pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      for (int l = 0; l < LANES; l++) begin
        logic [31:0] ja;
        ja = $urandom;
        set_lane(l, ($urandom_range(0, 3) != 0), 4'($urandom), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2),
                 ja, $urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? ja : $urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
